// File: rtl/fpu_sched_pkg.sv
// Shared types and constants for the FP-unit scheduler.
package fpu_sched_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_MUL = 1'b1
    } op_t;

    localparam logic [31:0] QNAN = 32'h7FC00000;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick: on a tie the requester that did not win last time goes.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] sel
);
    always_comb begin
        sel = req;
        if (req == 2'b11) sel = last ? 2'b01 : 2'b10;
    end
endmodule

// File: rtl/fpu_scheduler.sv
// Shares one FP unit between two requesters: round-robin grant, start/finish sequencing, done strobe.
// Optional watchdog abort (result = quiet NaN, err flag) when FPU_SCHED_TIMEOUT_EN is defined.
module fpu_scheduler
    import fpu_sched_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int SETTLE = 2
`ifdef FPU_SCHED_TIMEOUT_EN
   ,parameter int TIMEOUT = 255
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             mul0,
    input  logic             mul1,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             done0,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             busy,
`ifdef FPU_SCHED_TIMEOUT_EN
    output logic             err,
`endif
    output logic [WIDTH-1:0] fpu_a,
    output logic [WIDTH-1:0] fpu_b,
    output logic             fpu_mul,
    output logic             fpu_start,
    input  logic [WIDTH-1:0] fpu_s,
    input  logic             fpu_finish
);
    state_t     state, state_nxt;
    logic [1:0] sel;
    logic       last_grant;
    logic       owner;
    logic [3:0] settle_cnt;
    logic       fin_ok;
    logic       wd_hit;

    rr_arbiter2 u_arb (
        .req  ({req1, req0}),
        .last (last_grant),
        .sel  (sel)
    );

    assign fin_ok = (settle_cnt == 4'd0) && fpu_finish;

`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT + 1);
    logic [WD_W-1:0] wd_cnt;
    // A real finish on the last allowed cycle beats the abort.
    assign wd_hit = (wd_cnt == WD_W'(TIMEOUT - 1)) && !fin_ok;
`else
    assign wd_hit = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (|sel) state_nxt = ISSUE;
            ISSUE: state_nxt = WAIT;
            WAIT:  if (fin_ok || wd_hit) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        fpu_start = 1'b0;
        busy      = (state != IDLE);
        case (state)
            // gnt is combinational from req, so mask it while reset is held.
            IDLE:  if (!rst) {gnt1, gnt0} = sel;
            ISSUE: fpu_start = 1'b1;
            DONE:  begin
                done0 = !owner;
                done1 = owner;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_a      <= '0;
            fpu_b      <= '0;
            fpu_mul    <= OP_ADD;
            result     <= '0;
            owner      <= 1'b0;
            last_grant <= 1'b1;
            settle_cnt <= 4'd0;
`ifdef FPU_SCHED_TIMEOUT_EN
            err        <= 1'b0;
            wd_cnt     <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (|sel) begin
                    fpu_a   <= sel[1] ? a1 : a0;
                    fpu_b   <= sel[1] ? b1 : b0;
                    fpu_mul <= sel[1] ? mul1 : mul0;
                    owner   <= sel[1];
`ifdef FPU_SCHED_TIMEOUT_EN
                    err     <= 1'b0;
`endif
                end
                ISSUE: begin
                    settle_cnt <= 4'(SETTLE);
`ifdef FPU_SCHED_TIMEOUT_EN
                    wd_cnt     <= '0;
`endif
                end
                WAIT: begin
                    if (settle_cnt != 4'd0) settle_cnt <= settle_cnt - 4'd1;
                    else if (fpu_finish)    result     <= fpu_s;
`ifdef FPU_SCHED_TIMEOUT_EN
                    wd_cnt <= wd_cnt + 1'b1;
                    if (wd_hit) begin
                        result <= WIDTH'(QNAN);
                        err    <= 1'b1;
                    end
`endif
                end
                DONE: last_grant <= owner;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_scheduler.sv
// Self-checking bench for fpu_scheduler: latency-programmable FPU model, cycle-level reference, directed + random stimulus.
module tb_fpu_scheduler;
    localparam int SETTLE = 2;
`ifdef FPU_SCHED_TIMEOUT_EN
    localparam int TIMEOUT = 8;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req0 = 0, req1 = 0, mul0 = 0, mul1 = 0;
    logic [31:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
    logic gnt0, gnt1, done0, done1, busy, fpu_mul, fpu_start;
    logic [31:0] result, fpu_a, fpu_b;
    logic [31:0] fpu_s = 0;
    logic fpu_finish = 0;
`ifdef FPU_SCHED_TIMEOUT_EN
    logic err;
`endif

    always #5 clk = ~clk;

    fpu_scheduler #(
        .WIDTH(32), .SETTLE(SETTLE)
`ifdef FPU_SCHED_TIMEOUT_EN
       ,.TIMEOUT(TIMEOUT)
`endif
    ) dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .mul0(mul0), .mul1(mul1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1), .gnt0(gnt0), .gnt1(gnt1),
        .done0(done0), .done1(done1), .result(result), .busy(busy),
`ifdef FPU_SCHED_TIMEOUT_EN
        .err(err),
`endif
        .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_mul(fpu_mul), .fpu_start(fpu_start),
        .fpu_s(fpu_s), .fpu_finish(fpu_finish)
    );

    int n_tests = 0, n_fail = 0;
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // IEEE single <-> real (normal numbers only; operands kept well inside range)
    function automatic real f2r(input logic [31:0] x);
        logic [63:0] d;
        if (x[30:23] == 8'd0) return 0.0;
        d = {x[31], 11'(x[30:23]) + 11'd896, x[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction
    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        d = $realtobits(r);
        if (d[62:52] == 11'd0) return {d[63], 31'd0};
        return {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    endfunction
    function automatic logic [31:0] fp_calc(input logic [31:0] a, input logic [31:0] b, input logic m);
        return r2f(m ? f2r(a) * f2r(b) : f2r(a) + f2r(b));
    endfunction
    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(120, 135)), 23'($urandom)};
    endfunction

    // Behavioural FP unit: finish is a level; optionally keeps a stale finish/result after start.
    int lat = 3;
    bit stale_hold = 0, never = 0;
    int f_cnt;
    bit f_pend;
    logic [31:0] f_res;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            fpu_finish <= 0; fpu_s <= 0; f_pend <= 0; f_cnt <= 0;
        end else if (fpu_start) begin
            f_cnt  <= lat - 1;
            f_pend <= 1;
            f_res  <= fp_calc(fpu_a, fpu_b, fpu_mul);
            if (!stale_hold) fpu_finish <= 0;
        end else if (f_pend && !never) begin
            if (f_cnt <= 1) begin
                fpu_finish <= 1; fpu_s <= f_res; f_pend <= 0;
            end else f_cnt <= f_cnt - 1;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: one transaction at a time, timed by cycle arithmetic from the grant cycle.
    bit m_busy, m_last = 1, m_own, m_mul, m_err;
    int m_tg, m_dat, k;
    logic [31:0] m_a, m_b, m_res = 0;
    bit e_g0, e_g1, e_d0, e_d1, e_st, gr, w;
    always @(negedge clk) begin
        if (rst) begin
            m_busy = 0; m_last = 1; m_res = 0; m_err = 0;
            chk("rst_ctl", {25'd0, gnt0, gnt1, done0, done1, busy, fpu_start, fpu_mul}, 32'd0);
            chk("rst_result", result, 32'd0);
            chk("rst_fpu_ab", fpu_a | fpu_b, 32'd0);
`ifdef FPU_SCHED_TIMEOUT_EN
            chk("rst_err", {31'd0, err}, 32'd0);
`endif
        end else begin
            e_g0 = 0; e_g1 = 0; e_d0 = 0; e_d1 = 0; e_st = 0; gr = 0; w = 0;
            if (!m_busy) begin
                if (req0 && (!req1 || m_last)) begin gr = 1; w = 0; end
                else if (req1)                 begin gr = 1; w = 1; end
                e_g0 = gr && !w;
                e_g1 = gr && w;
            end else begin
                e_st = (cyc == m_tg + 1);
                e_d0 = (cyc == m_dat) && !m_own;
                e_d1 = (cyc == m_dat) && m_own;
            end
            chk("gnt0", {31'd0, gnt0}, {31'd0, e_g0});
            chk("gnt1", {31'd0, gnt1}, {31'd0, e_g1});
            chk("done0", {31'd0, done0}, {31'd0, e_d0});
            chk("done1", {31'd0, done1}, {31'd0, e_d1});
            chk("fpu_start", {31'd0, fpu_start}, {31'd0, e_st});
            chk("busy", {31'd0, busy}, {31'd0, m_busy});
            chk("result", result, m_res);
`ifdef FPU_SCHED_TIMEOUT_EN
            chk("err", {31'd0, err}, {31'd0, m_err});
`endif
            if (m_busy && cyc > m_tg) begin
                chk("fpu_a", fpu_a, m_a);
                chk("fpu_b", fpu_b, m_b);
                chk("fpu_mul", {31'd0, fpu_mul}, {31'd0, m_mul});
            end
            if (gr) begin
                m_busy = 1; m_tg = cyc; m_own = w; m_dat = -1; m_err = 0;
                m_a = w ? a1 : a0; m_b = w ? b1 : b0; m_mul = w ? mul1 : mul0;
            end else if (m_busy) begin
                if (cyc == m_dat) begin
                    m_busy = 0; m_last = m_own;
                end else if (m_dat < 0 && cyc >= m_tg + 2) begin
                    k = cyc - m_tg - 2;
                    if (k >= SETTLE && fpu_finish) begin
                        m_dat = cyc + 1; m_res = fpu_s;
                    end
`ifdef FPU_SCHED_TIMEOUT_EN
                    else if (k + 1 >= TIMEOUT) begin
                        m_dat = cyc + 1; m_res = 32'h7FC00000; m_err = 1;
                    end
`endif
                end
            end
        end
    end

    // Driver-side observation of each cycle
    bit auto_drop = 1, gs0, gs1, ds;
    int g_cyc, d_cyc, s_cyc, n_g1, n_d1, n_idle;
    bit g_own, d_own, d_err;
    logic [31:0] d_res;
    task automatic tick();
        @(negedge clk);
        gs0 = gnt0; gs1 = gnt1; ds = done0 | done1;
        if (gnt0 | gnt1) begin g_cyc = cyc; g_own = gnt1; end
        if (ds) begin
            d_cyc = cyc; d_own = done1; d_res = result;
`ifdef FPU_SCHED_TIMEOUT_EN
            d_err = err;
`else
            d_err = 0;
`endif
        end
        if (fpu_start) s_cyc = cyc;
        if (gnt1) n_g1++;
        if (done1) n_d1++;
        if (!busy) n_idle++;
        @(posedge clk); #1;
        if (auto_drop) begin
            if (gs0) req0 = 0;
            if (gs1) req1 = 0;
        end
    endtask
    task automatic wait_gnt(input string nm);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin tick(); got = gs0 | gs1; end
        if (!got) chk({nm, "_gnt_timeout"}, 0, 1);
    endtask
    task automatic wait_done(input string nm);
        bit got = 0;
        for (int i = 0; i < 200 && !got; i++) begin tick(); got = ds; end
        if (!got) chk({nm, "_done_timeout"}, 0, 1);
    endtask
    task automatic do_reset();
        rst = 1; tick(); tick(); rst = 0;
    endtask

    initial begin
        do_reset();

        // single multiply on port 0: 1.0 * 2.0, L = 5
        lat = 5; n_g1 = 0; n_d1 = 0;
        req0 = 1; mul0 = 1; a0 = 32'h3F800000; b0 = 32'h40000000;
        wait_gnt("t1"); chk("t1_owner", {31'd0, g_own}, 0);
        wait_done("t1");
        chk("t1_start_lat", s_cyc - g_cyc, 1);
        chk("t1_done_lat", d_cyc - g_cyc, 7);
        chk("t1_result", d_res, 32'h40000000);
        chk("t1_no_port1", n_g1 + n_d1, 0);

        // both held continuously after reset: 0,1,0,1
        do_reset();
        lat = 3; auto_drop = 0;
        req0 = 1; req1 = 1; mul0 = 0; mul1 = 1;
        a0 = rnd_fp(); b0 = rnd_fp(); a1 = rnd_fp(); b1 = rnd_fp();
        for (int i = 0; i < 4; i++) begin
            wait_gnt("alt");
            chk("alt_owner", {31'd0, g_own}, i % 2);
            if (i == 3) begin req0 = 0; req1 = 0; end
            wait_done("alt");
            chk("alt_done_owner", {31'd0, d_own}, i % 2);
        end
        auto_drop = 1;

        // stale finish still high from the previous op: 2.0 + 3.0 after settle
        stale_hold = 1; lat = 2;
        req0 = 1; mul0 = 0; a0 = 32'h40000000; b0 = 32'h40400000;
        wait_gnt("stale"); wait_done("stale");
        chk("stale_done_lat", d_cyc - g_cyc, 3 + SETTLE);
        chk("stale_result", d_res, 32'h40A00000);
        stale_hold = 0;

        // req1 arrives while req0 is in WAIT; granted in the single IDLE cycle after done0
        lat = 10;
        req0 = 1; a0 = rnd_fp(); b0 = rnd_fp();
        wait_gnt("bb"); tick(); tick(); tick();
        req1 = 1; a1 = rnd_fp(); b1 = rnd_fp(); mul1 = 0;
        n_idle = 0;
        wait_done("bb0"); chk("bb_done0_owner", {31'd0, d_own}, 0);
        wait_gnt("bb1");
        chk("bb_gnt1_gap", g_cyc - d_cyc, 1);
        chk("bb_gnt1_owner", {31'd0, g_own}, 1);
        wait_done("bb1");
        chk("bb_idle_cycles", n_idle, 1);

        // asynchronous reset in WAIT
        lat = 10; req0 = 1; a0 = rnd_fp(); b0 = rnd_fp();
        wait_gnt("rw"); tick(); tick(); tick();
        #3 rst = 1; #1;
        chk("rw_async_ctl", {26'd0, gnt0, gnt1, done0, done1, busy, fpu_start}, 0);
        chk("rw_async_data", result | fpu_a | fpu_b, 0);
        tick(); tick(); rst = 0;
        lat = 4; req0 = 1; a0 = rnd_fp(); b0 = rnd_fp(); mul0 = 1;
        wait_gnt("rw2"); chk("rw2_owner", {31'd0, g_own}, 0);
        wait_done("rw2"); chk("rw2_result", d_res, fp_calc(a0, b0, 1'b1));

`ifdef FPU_SCHED_TIMEOUT_EN
        never = 1; req0 = 1; a0 = rnd_fp(); b0 = rnd_fp();
        wait_gnt("wd"); wait_done("wd");
        chk("wd_done_lat", d_cyc - g_cyc, 2 + TIMEOUT);
        chk("wd_result", d_res, 32'h7FC00000);
        chk("wd_err", {31'd0, d_err}, 1);
        never = 0;
        do_reset();
`endif

        // random traffic
        for (int n = 0; n < 3000; n++) begin
            tick();
            if (!req0 && $urandom_range(0, 3) == 0) begin
                req0 = 1; a0 = rnd_fp(); b0 = rnd_fp(); mul0 = 1'($urandom_range(0, 1));
            end else if (req0 && $urandom_range(0, 29) == 0) req0 = 0;
            if (!req1 && $urandom_range(0, 3) == 0) begin
                req1 = 1; a1 = rnd_fp(); b1 = rnd_fp(); mul1 = 1'($urandom_range(0, 1));
            end else if (req1 && $urandom_range(0, 29) == 0) req1 = 0;
            if ($urandom_range(0, 15) == 0) lat = $urandom_range(2, 12);
            stale_hold = ($urandom_range(0, 7) == 0);
        end
        req0 = 0; req1 = 0; stale_hold = 0;
        begin
            bit idle = 0;
            for (int i = 0; i < 100 && !idle; i++) begin tick(); idle = !busy; end
            if (!idle) chk("drain_timeout", 0, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
